// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Sequences one shared combinational MAC unit (dout = w*i + o) through an
//   N-element dot product. A job (len, bias) is requested with start. Operand
//   pairs then stream in over a valid/ready handshake and are registered into
//   the MAC. The MAC outputs are summed in a saturating accumulator of width
//   AccWidth. The sum is returned over a valid/ready handshake.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   start, len, bias      job request (sampled in IDLE only), beat count, addend
//   abort                 synchronous cancel, wins over everything else
//   busy                  controller is not idle
//   op_valid/op_ready     operand pair handshake, operands on op_w / op_i
//   mac_nop_in            to MAC: 1 = bubble, 0 = live beat
//   mac_w, mac_i, mac_o   registered MAC operands and addend
//   mac_nop_out, mac_dout from MAC: bubble flag and product-plus-addend
//   res_valid/res_ready   result handshake, result on res_data / res_ovf
module mac_seq_ctrl #(
  parameter int DataInWidth  = 8,
  parameter int DataOutWidth = 16,
  parameter int AccWidth     = 24,
  parameter int LenWidth     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LenWidth-1:0]     len,
  input  logic [DataInWidth-1:0]  bias,
  input  logic                    abort,
  output logic                    busy,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [DataInWidth-1:0]  op_w,
  input  logic [DataInWidth-1:0]  op_i,
  output logic                    mac_nop_in,
  output logic [DataInWidth-1:0]  mac_w,
  output logic [DataInWidth-1:0]  mac_i,
  output logic [DataInWidth-1:0]  mac_o,
  input  logic                    mac_nop_out,
  input  logic [DataOutWidth-1:0] mac_dout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [AccWidth-1:0]     res_data,
  output logic                    res_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [LenWidth-1:0]   cnt;
  logic [AccWidth-1:0]   acc;
  logic                  ovf;
  logic                  first;
  logic                  beat;
  logic [AccWidth:0]     acc_sum;

  assign op_ready  = (state == RUN) && !abort;
  assign beat      = op_valid && op_ready;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = acc;
  assign res_ovf   = ovf;

  // One extra bit on the sum so a carry out of the accumulator shows up as
  // saturation instead of wrapping.
  assign acc_sum = {1'b0, acc} + {{(AccWidth + 1 - DataOutWidth){1'b0}}, mac_dout};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort overrides every other transition, including start and res_ready.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = (len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (beat && (cnt == LenWidth'(1))) begin
            state_next = DRAIN;
          end
        end
        DRAIN: begin
          state_next = DONE;
        end
        DONE: begin
          if (res_ready) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // A beat accepted at edge t sits in the mac_* registers after t. Its MAC
  // result is added at edge t+1. DRAIN therefore exists only to pick up the
  // product of the last beat. A zero-length job skips the MAC entirely and
  // returns the bias as the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      first      <= 1'b0;
      mac_w      <= '0;
      mac_i      <= '0;
      mac_o      <= '0;
      mac_nop_in <= 1'b1;
    end else if (abort) begin
      cnt        <= '0;
      acc        <= '0;
      mac_nop_in <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ovf <= 1'b0;
            if (len != '0) begin
              cnt   <= len;
              acc   <= '0;
              first <= 1'b1;
            end else begin
              acc <= {{(AccWidth - DataInWidth){1'b0}}, bias};
            end
          end
        end
        RUN, DRAIN: begin
          if (!mac_nop_out) begin
            if (acc_sum[AccWidth]) begin
              acc <= '1;
              ovf <= 1'b1;
            end else begin
              acc <= acc_sum[AccWidth-1:0];
            end
          end
          if (state == DRAIN) begin
            mac_nop_in <= 1'b1;
          end else if (beat) begin
            mac_w      <= op_w;
            mac_i      <= op_i;
            mac_o      <= first ? bias : '0;
            mac_nop_in <= 1'b0;
            first      <= 1'b0;
            cnt        <= cnt - LenWidth'(1);
          end else begin
            mac_w      <= '0;
            mac_i      <= '0;
            mac_o      <= '0;
            mac_nop_in <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
